// File: rtl/key_conditioner_if.sv
// Board-key bundle between the raw KEY pins and the conditioned outputs.
// The slave modport is the conditioner; the master modport drives the keys and observes results.
interface key_conditioner_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                cpu_rst;

  // Level-style interface, no handshake: key_n is sampled every clock, outputs are
  // registered and valid on every cycle; press/release are one-cycle strobes.
  modport master (
    output key_n,
    input  key_level, key_press, key_release, cpu_rst
  );

  modport slave (
    input  key_n,
    output key_level, key_press, key_release, cpu_rst
  );
endinterface

// File: rtl/key_conditioner.sv
// Synchronises and debounces active-low push-buttons, emits press/release strobes and a
// reset request for the core. Define KEY_COND_RST_STRETCH_EN to stretch cpu_rst after key0/reset.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  key_conditioner_if.slave  kif
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [NUM_KEYS-1:0]  sync1_q;
  logic [NUM_KEYS-1:0]  samp_q;
  logic [NUM_KEYS-1:0]  level_q, level_d;
  logic [NUM_KEYS-1:0]  press_q, press_d;
  logic [NUM_KEYS-1:0]  release_q, release_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_KEYS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_KEYS];
  logic                 cpu_rst_q, cpu_rst_d;

  // Two-flop synchroniser; inversion makes 1 mean pressed from here on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      samp_q  <= '0;
    end else begin
      sync1_q <= ~kif.key_n;
      samp_q  <= sync1_q;
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = '0;
      if (samp_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i]   = samp_q[i];
          press_d[i]   = samp_q[i];
          release_d[i] = level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef KEY_COND_RST_STRETCH_EN
  localparam int                HCNT_W   = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HCNT_W-1:0] HOLD     = HCNT_W'(RST_HOLD_CYCLES);
  localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  // cpu_rst follows the post-edge hold count so it drops exactly RST_HOLD_CYCLES edges
  // after reset release or after key_level[0] falls.
  always_comb begin
    hcnt_d = hcnt_q;
    if (level_q[0]) begin
      hcnt_d = HOLD;
    end else if (hcnt_q != '0) begin
      hcnt_d = hcnt_q - HCNT_ONE;
    end
    cpu_rst_d = level_q[0] | (hcnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= HOLD;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end
`else
  assign cpu_rst_d = level_q[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rst_q <= 1'b1;
    end else begin
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign kif.key_level   = level_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
  assign kif.cpu_rst     = cpu_rst_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: reference model from the debounce rules, vector table,
// corner-case sequences and randomized key patterns.
module tb_key_conditioner;

  localparam int NK   = 4;
  localparam int DB   = 8;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_conditioner_if #(.NUM_KEYS(NK)) kif ();

  key_conditioner #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH(4),
    .RST_HOLD_CYCLES(HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NK-1:0] m_s1, m_s2, m_level, m_press, m_rel;
  logic          m_cpu;
  int            m_since;
  logic [DB-1:0] hist [NK];

  typedef struct {
    logic [NK-1:0] key_n;
    int            cycles;
    logic [NK-1:0] exp_level;
    logic          exp_cpu;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
    m_cpu = 1'b1;
    m_since = 0;
    for (int k = 0; k < NK; k++) hist[k] = '0;
  endtask

  // A key changes once its last DB synchronised samples all disagree with its level.
  task automatic model_edge();
    logic old0;
    old0 = m_level[0];
    m_press = '0;
    m_rel   = '0;
    for (int k = 0; k < NK; k++) begin
      hist[k] = {hist[k][DB-2:0], m_s2[k]};
      if (hist[k] == {DB{~m_level[k]}}) begin
        m_level[k] = ~m_level[k];
        if (m_level[k]) m_press[k] = 1'b1;
        else            m_rel[k]   = 1'b1;
      end
    end
`ifdef KEY_COND_RST_STRETCH_EN
    if (old0) m_since = 0;
    else if (m_since < HOLD) m_since++;
    m_cpu = (m_since < HOLD);
`else
    m_cpu = old0;
`endif
    m_s2 = m_s1;
    m_s1 = ~kif.key_n;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check("level",   kif.key_level,   m_level);
    check("press",   kif.key_press,   m_press);
    check("release", kif.key_release, m_rel);
    check("cpu_rst", kif.cpu_rst,     m_cpu);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    kif.key_n = '1;
    model_reset();

    vecs[0] = '{4'b1111, 16, 4'b0000, 1'b0};
    vecs[1] = '{4'b1110, 16, 4'b0001, 1'b1};
    vecs[2] = '{4'b1111, 16, 4'b0000, 1'b0};
    vecs[3] = '{4'b0101, 16, 4'b1010, 1'b0};
    vecs[4] = '{4'b0000, 16, 4'b1111, 1'b1};
    vecs[5] = '{4'b1111, 16, 4'b0000, 1'b0};
    vecs[6] = '{4'b0111, 16, 4'b1000, 1'b0};
    vecs[7] = '{4'b1111, 16, 4'b0000, 1'b0};

    // Reset state
    ticks(2);
    check("reset_level", kif.key_level, 4'b0000);
    check("reset_cpu",   kif.cpu_rst,   1'b1);
    rst = 1'b0;

    // Vector table
    for (int v = 0; v < 8; v++) begin
      kif.key_n = vecs[v].key_n;
      ticks(vecs[v].cycles);
      check($sformatf("vec%0d_level", v), kif.key_level, vecs[v].exp_level);
      check($sformatf("vec%0d_cpu", v),   kif.cpu_rst,   vecs[v].exp_cpu);
    end

    // Clean press of key1: level and pulse at edge 10
    kif.key_n = 4'b1101;
    ticks(9);
    check("press_early", kif.key_level[1], 1'b0);
    tick();
    check("press_level", kif.key_level, 4'b0010);
    check("press_pulse", kif.key_press, 4'b0010);
    tick();
    check("press_once",  kif.key_press, 4'b0000);

    // Bounce on key2: 5 low, 1 high, then held low
    kif.key_n = 4'b1001;
    ticks(5);
    check("bounce_none", kif.key_level[2], 1'b0);
    kif.key_n = 4'b1101;
    tick();
    kif.key_n = 4'b1001;
    ticks(9);
    check("bounce_early", kif.key_level[2], 1'b0);
    tick();
    check("bounce_level", kif.key_level[2], 1'b1);
    check("bounce_press", kif.key_press, 4'b0100);
    ticks(10);

    // Release of key1
    kif.key_n = 4'b1011;
    ticks(9);
    check("rel_early", kif.key_level[1], 1'b1);
    tick();
    check("rel_level",    kif.key_level,   4'b0100);
    check("rel_pulse",    kif.key_release, 4'b0010);
    check("rel_no_press", kif.key_press,   4'b0000);

    // Simultaneous press of keys 1 and 3
    kif.key_n = 4'b0001;
    ticks(10);
    check("simul_level", kif.key_level, 4'b1110);
    check("simul_press", kif.key_press, 4'b1010);
    kif.key_n = 4'b1111;
    ticks(12);

    // Reset mid-count on key2 (count reaches 5 after 7 edges)
    kif.key_n = 4'b1011;
    ticks(7);
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_level",   kif.key_level,   4'b0000);
    check("arst_press",   kif.key_press,   4'b0000);
    check("arst_release", kif.key_release, 4'b0000);
    check("arst_cpu",     kif.cpu_rst,     1'b1);
    ticks(2);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
`ifdef KEY_COND_RST_STRETCH_EN
      if (i == 3) check("stretch_hold", kif.cpu_rst, 1'b1);
      if (i == 4) check("stretch_fall", kif.cpu_rst, 1'b0);
`else
      if (i == 1) check("cpu_rst_fall", kif.cpu_rst, 1'b0);
`endif
      if (i == 9)  check("rst_restart_early", kif.key_level[2], 1'b0);
      if (i == 10) check("rst_restart",       kif.key_level[2], 1'b1);
    end
    kif.key_n = 4'b1111;
    ticks(12);

    // Key0 drives cpu_rst; release timing of the request
    kif.key_n = 4'b1110;
    ticks(12);
    check("key0_held", kif.cpu_rst, 1'b1);
    kif.key_n = 4'b1111;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 10) check("key0_level_fall", kif.key_level[0], 1'b0);
`ifdef KEY_COND_RST_STRETCH_EN
      if (i == 13) check("key0_stretch_hold", kif.cpu_rst, 1'b1);
      if (i == 14) check("key0_stretch_fall", kif.cpu_rst, 1'b0);
`else
      if (i == 10) check("key0_cpu_hold", kif.cpu_rst, 1'b1);
      if (i == 11) check("key0_cpu_fall", kif.cpu_rst, 1'b0);
`endif
    end

    // Randomized key patterns with hold times around the debounce window
    for (int s = 0; s < 200; s++) begin
      kif.key_n = NK'($urandom_range(0, 15));
      ticks($urandom_range(1, 14));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
